// File: rtl/stream_demux_if.sv
// Stream demux bus: one upstream valid/ready port fanned out to NCH channels.
// The slave modport is the demux side; master is the producer/consumer side.
interface stream_demux_if #(
  parameter int DW   = 8,
  parameter int NCH  = 8,
  parameter int SELW = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic [SELW-1:0]   in_sel;
  logic [NCH-1:0]    out_valid;
  logic [NCH-1:0]    out_ready;
  logic [NCH*DW-1:0] out_data;
  logic [15:0]       drop_cnt;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, drop_cnt
  );
endinterface

// File: rtl/stream_demux.sv
// 1-to-NCH stream demux with a one-entry holding slot per channel.
// Define STREAM_DEMUX_DROP_CNT_EN to count discarded out-of-range beats.
module stream_demux #(
  parameter int DW   = 8,
  parameter int NCH  = 8,
  parameter int SELW = 3
) (
  input logic           clk,
  input logic           rst_n,
  stream_demux_if.slave bus
);

  logic [NCH-1:0]         vld_q;
  logic [NCH-1:0][DW-1:0] dat_q;
  logic                   live_q;
  logic                   in_range;
  logic [NCH-1:0]         sel_oh;
  logic                   rdy;
  logic                   take;

  always_comb begin
    in_range = int'(bus.in_sel) < NCH;
    sel_oh   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (in_range && bus.in_sel == SELW'(k))
        sel_oh[k] = 1'b1;
    end
  end

  // Only the selected slot's ready feeds back to upstream.
  always_comb begin
    rdy = 1'b0;
    unique case (1'b1)
      !live_q:
        rdy = 1'b0;
      live_q && !in_range:
        rdy = 1'b1;
      default:
        rdy = |(sel_oh & (~vld_q | bus.out_ready));
    endcase
  end

  assign take         = bus.in_valid & rdy;
  assign bus.in_ready = rdy;

  // Blocks acceptance on the edge that coincides with reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      live_q <= 1'b0;
    else
      live_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (take && sel_oh[k]) begin
          vld_q[k] <= 1'b1;
          dat_q[k] <= bus.in_data;
        end else if (bus.out_ready[k]) begin
          vld_q[k] <= 1'b0;
        end
      end
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.out_data  = dat_q;

`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_q <= '0;
    else if (take && !in_range && drop_q != 16'hFFFF)
      drop_q <= drop_q + 16'd1;
  end

  assign bus.drop_cnt = drop_q;
`else
  assign bus.drop_cnt = '0;
`endif

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter DW, default 8, data width in bits (1..64).
REQ-002 Parameter NCH, default 8, number of output channels (2..16).
REQ-003 Parameter SELW, default 3, select width; SELW SHALL satisfy 2**SELW >= NCH.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream beat present.
REQ-007 in_ready  output  1  beat accepted this cycle when high with in_valid.
REQ-008 in_data  input  DW  upstream payload.
REQ-009 in_sel  input  SELW  destination channel index.
REQ-010 out_valid  output  NCH  bit k high: channel k holds a beat.
REQ-011 out_ready  input  NCH  bit k high: channel k consumer takes its beat.
REQ-012 out_data  output  NCH*DW  channel k payload at bits [k*DW +: DW].
REQ-013 drop_cnt  output  16  count of beats discarded for out-of-range select.

Function
REQ-014 Each channel SHALL own a one-entry holding register (valid flag plus DW data).
REQ-015 A transfer SHALL occur on a rising edge where in_valid and in_ready are both high.
REQ-016 For in_sel < NCH, in_ready SHALL be combinationally high when slot in_sel is empty or out_ready[in_sel] is high in the same cycle.
REQ-017 For in_sel >= NCH, in_ready SHALL be high unconditionally, and the beat SHALL be discarded.
REQ-018 An accepted in-range beat SHALL appear on out_valid[in_sel]/out_data[in_sel] exactly one cycle after acceptance.
REQ-019 Channel k SHALL drain on an edge where out_valid[k] and out_ready[k] are both high, and out_valid[k] SHALL then clear unless a new beat loads the same edge.
REQ-020 A simultaneous drain and load on the same channel SHALL replace the data and keep out_valid[k] high, sustaining one beat per cycle per channel.
REQ-021 Only the selected channel SHALL change on a load; all other channels SHALL be unaffected except by their own drains.
REQ-022 out_data[k] SHALL hold its last loaded value while out_valid[k] is low, and SHALL never be X.
REQ-023 A beat held in channel k SHALL remain stable, with data unchanged, until drained, regardless of out_ready on other channels.
REQ-024 in_ready SHALL not depend on out_ready of any non-selected channel.
REQ-025 in_sel and in_data SHALL be sampled only on an accepting edge; values while in_valid is low SHALL be ignored.

Reset
REQ-026 While rst_n is low, out_valid SHALL be all zeros, out_data all zeros, and drop_cnt zero, applied asynchronously.
REQ-027 in_ready while rst_n is low SHALL be 0.
REQ-028 Beats held at reset assertion SHALL be lost, and no beat SHALL be accepted on the first edge after release if it coincides with rst_n rising.
REQ-029 Reset deassertion SHALL be treated as synchronous to clk, with no internal synchronizer.

Configuration
REQ-030 Macro STREAM_DEMUX_DROP_CNT_EN defined: drop_cnt SHALL increment by 1 per discarded out-of-range beat and saturate at 16'hFFFF, with no wrap.
REQ-031 Macro STREAM_DEMUX_DROP_CNT_EN undefined: drop_cnt SHALL be a constant 0, with no counter logic; all other behaviour SHALL be identical.

Verification
REQ-032 Default parameters, reset, then in_sel=3, in_data=8'hA5, one beat, out_ready=0 -> next cycle out_valid=8'b0000_1000, out_data[31:24]=8'hA5, and in_ready for sel 3 = 0 while held.
REQ-033 Channel 5: streaming 8'h01..8'h10 back-to-back with out_ready[5]=1 -> in_ready held high, 16 beats out in order, one per cycle, with 1-cycle latency.
REQ-034 Channel 2 full with out_ready[2]=0, then beat to sel=6 -> accepted, out_valid[6]=1, and channel 2 data unchanged.
REQ-035 NCH=6, in_sel=7, 3 beats with STREAM_DEMUX_DROP_CNT_EN defined -> in_ready=1, no out_valid set, drop_cnt=3; with the macro undefined -> drop_cnt=0.
REQ-036 rst_n pulsed low asynchronously mid-stream with channels 0 and 7 full -> out_valid=0, out_data=0 and drop_cnt=0 immediately, without waiting for a clock edge.
REQ-037 drop_cnt forced near 16'hFFFE, then 4 out-of-range beats -> drop_cnt stays 16'hFFFF.
